spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_slave.sv | 149 ++++++++++++++
 tb/tb_spi_slave.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | spi_pkg: shared constants for the SPI slave (sync depth, mode-0 edges).   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package spi_pkg;

  localparam int c_sync_depth = 3;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_sel_t;

  // Mode 0: sample mosi on sclk rise, advance miso on sclk fall.
  localparam edge_sel_t c_sample_edge = EDGE_RISE;
  localparam edge_sel_t c_shift_edge  = EDGE_FALL;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | spi_sync_edge: 2-flop synchronizer plus one history flop for edge detect. |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync_level,
  output logic rise,
  output logic fall
);

  logic [c_sync_depth-1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= {c_sync_depth{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[c_sync_depth-2:0], din};
    end
  end

  assign sync_level = r_sync[c_sync_depth-2];
  assign rise       =  r_sync[c_sync_depth-2] & ~r_sync[c_sync_depth-1];
  assign fall       = ~r_sync[c_sync_depth-2] &  r_sync[c_sync_depth-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | spi_slave: mode-0 SPI slave, oversampled on clk. LSB-first by default;    |
// | define SPI_SLAVE_MSB_FIRST_EN for MSB-first.   Revision: 1.0              |
// +---------------------------------------------------------------------------+
module spi_slave
  import spi_pkg::*;
#(
  parameter int TXWIDTH = 8,
  parameter int RXWIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sclk,
  input  logic               mosi,
  output logic               miso,
  input  logic               ss,
  input  logic [TXWIDTH-1:0] tx_buffer,
  input  logic               wr,
  output logic [RXWIDTH-1:0] rx_buffer
);

  localparam int c_tx_cw = $clog2(TXWIDTH);
  localparam int c_rx_cw = $clog2(RXWIDTH);
  localparam logic [c_tx_cw-1:0] c_tx_last = c_tx_cw'(TXWIDTH - 1);
  localparam logic [c_rx_cw-1:0] c_rx_last = c_rx_cw'(RXWIDTH - 1);
  localparam logic c_sample_level = (c_sample_edge == EDGE_RISE);
  localparam logic c_shift_level  = (c_shift_edge == EDGE_RISE);

  logic                    w_sclk_level;
  logic                    w_sclk_rise;
  logic                    w_sclk_fall;
  logic                    w_ss_level;
  logic                    w_ss_rise;
  logic                    w_ss_fall;
  logic                    w_sample;
  logic                    w_shift;
  logic                    w_mosi;
  logic                    w_tx_bit;
  logic [TXWIDTH-1:0]      w_tx_word;
  logic [TXWIDTH-1:0]      w_tx_shifted;
  logic [RXWIDTH-1:0]      w_rx_next;

  logic [c_sync_depth-2:0] r_mosi_sync;
  logic [TXWIDTH-1:0]      r_tx_hold;
  logic [TXWIDTH-1:0]      r_tx_shift;
  logic [RXWIDTH-1:0]      r_rx_shift;
  logic [c_tx_cw-1:0]      r_tx_cnt;
  logic [c_rx_cw-1:0]      r_rx_cnt;
  logic                    r_rx_done;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clk        (clk),
    .rst        (rst),
    .din        (sclk),
    .sync_level (w_sclk_level),
    .rise       (w_sclk_rise),
    .fall       (w_sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_ss_sync (
    .clk        (clk),
    .rst        (rst),
    .din        (ss),
    .sync_level (w_ss_level),
    .rise       (w_ss_rise),
    .fall       (w_ss_fall)
  );

  // mosi uses the same two-flop depth so it stays aligned with the sclk edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[c_sync_depth-3:0], mosi};
    end
  end

  assign w_mosi   = r_mosi_sync[c_sync_depth-2];
  assign w_sample = (w_sclk_rise | w_sclk_fall) & (w_sclk_level == c_sample_level);
  assign w_shift  = (w_sclk_rise | w_sclk_fall) & (w_sclk_level == c_shift_level);

`ifdef SPI_SLAVE_MSB_FIRST_EN
  assign w_rx_next    = {r_rx_shift[RXWIDTH-2:0], w_mosi};
  assign w_tx_shifted = {r_tx_shift[TXWIDTH-2:0], 1'b0};
  assign w_tx_bit     = r_tx_shift[TXWIDTH-1];
`else
  assign w_rx_next    = {w_mosi, r_rx_shift[RXWIDTH-1:1]};
  assign w_tx_shifted = {1'b0, r_tx_shift[TXWIDTH-1:1]};
  assign w_tx_bit     = r_tx_shift[0];
`endif

  // A write landing on the word-start cycle must win over the stale holding value.
  assign w_tx_word = wr ? tx_buffer : r_tx_hold;
  assign miso      = ~w_ss_level & w_tx_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_hold  <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_tx_cnt   <= '0;
      r_rx_cnt   <= '0;
      r_rx_done  <= 1'b0;
      rx_buffer  <= '0;
    end else begin
      r_rx_done <= 1'b0;
      if (wr) begin
        r_tx_hold <= tx_buffer;
      end
      if (r_rx_done) begin
        rx_buffer <= r_rx_shift;
      end

      if (w_ss_level) begin
        r_tx_cnt <= '0;
        r_rx_cnt <= '0;
        if (w_ss_rise) begin
          r_tx_shift <= '0;
        end
      end else if (w_ss_fall) begin
        r_tx_shift <= w_tx_word;
        r_tx_cnt   <= '0;
        r_rx_cnt   <= '0;
      end else begin
        if (w_sample) begin
          r_rx_shift <= w_rx_next;
          if (r_rx_cnt == c_rx_last) begin
            r_rx_cnt  <= '0;
            r_rx_done <= 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        if (w_shift) begin
          if (r_tx_cnt == c_tx_last) begin
            r_tx_cnt   <= '0;
            r_tx_shift <= w_tx_word;
          end else begin
            r_tx_cnt   <= r_tx_cnt + 1'b1;
            r_tx_shift <= w_tx_shifted;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_spi_slave: directed table-driven bench for spi_slave, 4-bit words.     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_spi_slave;

`ifdef SPI_SLAVE_MSB_FIRST_EN
  localparam bit c_msb_first = 1'b1;
`else
  localparam bit c_msb_first = 1'b0;
`endif
  localparam int c_half = 17;

  logic       clk;
  logic       rst;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       ss;
  logic [3:0] tx_buffer;
  logic       wr;
  logic [3:0] rx_buffer;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] tx;
    logic [3:0] mosi_word;
    logic [3:0] exp_rx;
    logic [3:0] exp_miso;
  } vec_t;

  vec_t vecs[5];

  spi_slave #(.TXWIDTH(4), .RXWIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .ss        (ss),
    .tx_buffer (tx_buffer),
    .wr        (wr),
    .rx_buffer (rx_buffer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One mode-0 bit: mosi set in the low phase, miso captured just before the rise.
  task automatic send_bit(input logic b, output logic m);
    mosi = b;
    wait_clk(c_half);
    m    = miso;
    sclk = 1'b1;
    wait_clk(c_half);
    sclk = 1'b0;
  endtask

  // Bits of w go out in wire order; miso samples are stored at the matching bit index.
  task automatic send_word(input logic [3:0] w, output logic [3:0] m);
    logic b;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = c_msb_first ? 3 - i : i;
      send_bit(w[idx], b);
      m[idx] = b;
    end
  endtask

  task automatic pulse_wr(input logic [3:0] val);
    tx_buffer = val;
    wr        = 1'b1;
    @(negedge clk);
    wr        = 1'b0;
  endtask

  task automatic select;
    ss = 1'b0;
    wait_clk(c_half);
  endtask

  task automatic deselect;
    ss = 1'b1;
    wait_clk(c_half);
  endtask

  initial begin
    logic [3:0] m;
    logic [3:0] m2;
    logic [3:0] seq;
    logic       b;

    vecs[0] = '{tx: 4'hC, mosi_word: 4'hA, exp_rx: 4'hA, exp_miso: 4'hC};
    vecs[1] = '{tx: 4'h3, mosi_word: 4'h5, exp_rx: 4'h5, exp_miso: 4'h3};
    vecs[2] = '{tx: 4'hF, mosi_word: 4'h0, exp_rx: 4'h0, exp_miso: 4'hF};
    vecs[3] = '{tx: 4'h0, mosi_word: 4'hF, exp_rx: 4'hF, exp_miso: 4'h0};
    vecs[4] = '{tx: 4'h6, mosi_word: 4'h9, exp_rx: 4'h9, exp_miso: 4'h6};

    rst = 1'b0; sclk = 1'b0; mosi = 1'b0; ss = 1'b1; tx_buffer = '0; wr = 1'b0;
    wait_clk(5);
    check("reset_rx", {4'h0, rx_buffer}, 8'h00);
    check("reset_miso", {7'h0, miso}, 8'h00);
    rst = 1'b1;
    wait_clk(5);

    // Receive 0,1,0,1 (LSB-first) or 1,0,1,0 (MSB-first): both give 4'b1010.
    seq = c_msb_first ? 4'b0101 : 4'b1010;
    select();
    for (int i = 0; i < 3; i++) send_bit(seq[i], b);
    mosi = seq[3];
    wait_clk(c_half);
    sclk = 1'b1;
    wait_clk(2);
    check("rx_hold_before_done", {4'h0, rx_buffer}, 8'h00);
    wait_clk(2);
    check("rx_4clk_after_edge", {4'h0, rx_buffer}, 8'h0A);
    wait_clk(c_half - 4);
    sclk = 1'b0;
    wait_clk(c_half);
    deselect();

    for (int v = 0; v < 5; v++) begin
      pulse_wr(vecs[v].tx);
      select();
      send_word(vecs[v].mosi_word, m);
      check($sformatf("vec%0d_rx", v), {4'h0, rx_buffer}, {4'h0, vecs[v].exp_rx});
      check($sformatf("vec%0d_miso", v), {4'h0, m}, {4'h0, vecs[v].exp_miso});
      deselect();
    end

    // Abort after 2 bits, then a full word.
    select();
    send_bit(1'b1, b);
    send_bit(1'b1, b);
    deselect();
    check("abort_rx_hold", {4'h0, rx_buffer}, 8'h09);
    select();
    send_word(4'h5, m);
    check("abort_new_word", {4'h0, rx_buffer}, 8'h05);
    deselect();

    // Back-to-back words; holding register updated mid-word1 feeds word2.
    pulse_wr(4'h5);
    select();
    m = '0; m2 = '0;
    for (int i = 0; i < 8; i++) begin
      int idx;
      logic [3:0] w;
      w   = (i < 4) ? 4'h3 : 4'h9;
      idx = c_msb_first ? 3 - (i % 4) : (i % 4);
      send_bit(w[idx], b);
      if (i < 4) m[idx] = b; else m2[idx] = b;
      if (i == 1) pulse_wr(4'hA);
      if (i == 3) check("b2b_rx_word1", {4'h0, rx_buffer}, 8'h03);
    end
    check("b2b_rx_word2", {4'h0, rx_buffer}, 8'h09);
    check("b2b_miso_word1", {4'h0, m}, 8'h05);
    check("b2b_miso_word2", {4'h0, m2}, 8'h0A);
    deselect();

    // wr on exactly the cycle the synchronized ss fall loads the shift register.
    tx_buffer = 4'h1;
    ss = 1'b0;
    wait_clk(2);
    tx_buffer = 4'h6;
    wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    tx_buffer = 4'hF;
    wait_clk(c_half - 3);
    send_word(4'hE, m);
    check("wr_at_load_miso", {4'h0, m}, 8'h06);
    check("wr_at_load_rx", {4'h0, rx_buffer}, 8'h0E);
    deselect();

    // Reset mid-word, then a clean frame.
    select();
    send_bit(1'b1, b);
    send_bit(1'b1, b);
    rst = 1'b0;
    wait_clk(3);
    check("midrst_rx", {4'h0, rx_buffer}, 8'h00);
    check("midrst_miso", {7'h0, miso}, 8'h00);
    rst = 1'b1;
    deselect();
    pulse_wr(4'h3);
    select();
    send_word(4'hA, m);
    check("after_rst_rx", {4'h0, rx_buffer}, 8'h0A);
    check("after_rst_miso", {4'h0, m}, 8'h03);
    deselect();
    check("idle_miso", {7'h0, miso}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
